// File: rtl/div16x8_pkg.sv
// Shared types and constants for the 16/8 restoring divider.
// Error-result values and the overflow rule live here.
package div_pkg;

    localparam int DVD_W = 16;
    localparam int DVS_W = 8;
    localparam int ITER  = 8;
    localparam int CNT_W = 4;

    localparam logic [DVS_W-1:0] ERR_QUO = 8'hFF;
    localparam logic [DVS_W-1:0] ERR_REM = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // The quotient fits in 8 bits only while the dividend high byte is below the divisor.
    function automatic logic too_big(
        input logic [DVS_W:0]   hi,
        input logic [DVS_W-1:0] dvs
    );
        return hi >= {1'b0, dvs};
    endfunction

endpackage

// File: rtl/div16x8_if.sv
// Operand/result bundle between a requester and the divider.
// master drives operands and start; slave returns registered results.
interface div16x8_if;
    import div_pkg::*;

    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             start;
    logic [DVS_W-1:0] quotient_out;
    logic [DVS_W-1:0] remainder_out;
    logic             done_flag;
    logic             div_zero_flag;
    logic             overflow_flag;

    modport master (
        output dividend,
        output divisor,
        output start,
        input  quotient_out,
        input  remainder_out,
        input  done_flag,
        input  div_zero_flag,
        input  overflow_flag
    );

    modport slave (
        input  dividend,
        input  divisor,
        input  start,
        output quotient_out,
        output remainder_out,
        output done_flag,
        output div_zero_flag,
        output overflow_flag
    );

endinterface

// File: rtl/div16x8_step.sv
// One restoring trial-subtract step: 9-bit shifted partial remainder in,
// next partial remainder and one quotient bit out.
module div16x8_step
    import div_pkg::*;
(
    input  logic [DVS_W:0]   pr_i,
    input  logic [DVS_W-1:0] dvs_i,
    output logic [DVS_W:0]   rem_o,
    output logic             qbit_o
);

    logic [DVS_W:0] trial;
    logic           borrow;

    assign {borrow, trial} = {1'b0, pr_i} - {2'b00, dvs_i};
    assign qbit_o          = ~borrow;
    assign rem_o           = borrow ? pr_i : trial;

endmodule

// File: rtl/div16x8.sv
// 16-bit by 8-bit restoring divider, one quotient bit per clock.
// Results are published only at completion; partial values stay internal.
module div16x8
    import div_pkg::*;
(
    input  logic     clk,
    input  logic     reset_a,
    div16x8_if.slave bus
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [DVS_W:0]   rem_q,   rem_d;
    logic [DVS_W-1:0] sh_q,    sh_d;
    logic [DVS_W-1:0] dvs_q,   dvs_d;
    logic [DVS_W-1:0] quo_q,   quo_d;
    logic [DVS_W-1:0] rmo_q,   rmo_d;
    logic             done_q,  done_d;
    logic             dz_q,    dz_d;
    logic             ov_q,    ov_d;

    logic [DVS_W:0]   step_pr;
    logic [DVS_W:0]   step_rem;
    logic             step_q;

    // sh_q shifts dividend bits out the top while quotient bits enter below.
    assign step_pr = {rem_q[DVS_W-1:0], sh_q[DVS_W-1]};

    div16x8_step u_step (
        .pr_i   (step_pr),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_a) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        done_d  = done_q;
        dz_d    = dz_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CALC: begin
                if (cnt_q == '0 && dvs_q == '0) begin
                    quo_d   = ERR_QUO;
                    rmo_d   = ERR_REM;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == '0 && too_big(rem_q, dvs_q)) begin
                    quo_d   = ERR_QUO;
                    rmo_d   = ERR_REM;
                    ov_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = step_rem;
                    sh_d  = {sh_q[DVS_W-2:0], step_q};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        quo_d   = {sh_q[DVS_W-2:0], step_q};
                        rmo_d   = step_rem[DVS_W-1:0];
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start sample relaunches from any state and wipes visible results.
        if (bus.start) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = {1'b0, bus.dividend[DVD_W-1:DVS_W]};
            sh_d    = bus.dividend[DVS_W-1:0];
            dvs_d   = bus.divisor;
            quo_d   = '0;
            rmo_d   = '0;
            done_d  = 1'b0;
            dz_d    = 1'b0;
            ov_d    = 1'b0;
        end
    end

    assign bus.quotient_out  = quo_q;
    assign bus.remainder_out = rmo_q;
    assign bus.done_flag     = done_q;
    assign bus.div_zero_flag = dz_q;
    assign bus.overflow_flag = ov_q;

endmodule

// File: tb/tb_div16x8.sv
// Randomized and directed bench for div16x8 against an arithmetic model.
// Observed word = {quotient, remainder, done, div_zero, overflow}.
module tb_div16x8;

    logic clk;
    logic reset_a;
    int   n_chk;
    int   n_err;

    div16x8_if bus ();

    div16x8 dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%05h exp=%05h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return {13'b0, bus.quotient_out, bus.remainder_out,
                bus.done_flag, bus.div_zero_flag, bus.overflow_flag};
    endfunction

    function automatic logic [31:0] model(input int dvd, input int dvs);
        int q;
        int r;
        if (dvs == 0)
            return {13'b0, 8'hFF, 8'h00, 3'b110};
        if (dvd / 256 >= dvs)
            return {13'b0, 8'hFF, 8'h00, 3'b101};
        q = dvd / dvs;
        r = dvd % dvs;
        return {13'b0, q[7:0], r[7:0], 3'b100};
    endfunction

    // hold = number of edges start stays high; outputs must read 0 on each.
    task automatic run(input string tag, input logic [15:0] dvd,
                       input logic [7:0] dvs, input int hold);
        logic [31:0] exp;
        int          lat;
        exp = model(int'(dvd), int'(dvs));
        lat = (exp[1:0] != 2'b00) ? 1 : 8;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_start"}, obs(), 32'd0);
        end
        bus.start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
            tick();
            if (i < lat)
                chk({tag, "_busy"}, obs(), 32'd0);
            else
                chk({tag, "_res"}, obs(), exp);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  rv;
        int          sel;
        n_chk        = 0;
        n_err        = 0;
        reset_a      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 8'hFF;
        tick();
        tick();
        chk("reset", obs(), 32'd0);
        reset_a = 1'b1;
        tick();
        chk("idle", obs(), 32'd0);

        run("exact", 16'd1700, 8'd100, 1);
        run("rem", 16'd1705, 8'd100, 1);
        run("ext", 16'd65024, 8'd255, 1);
        run("d98", 16'd98, 8'd7, 1);
        run("dz", 16'd1000, 8'd0, 1);
        run("ovf", 16'h1234, 8'h12, 1);
        run("zero_dvd", 16'd0, 8'd1, 1);
        run("max_nov", 16'h00FF, 8'd1, 1);
        run("ovf_edge", 16'h0100, 8'd1, 1);

        bus.dividend = 16'd5358;
        bus.divisor  = 8'd57;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("rst1_busy", obs(), 32'd0);
        end
        run("restart", 16'd7424, 8'd232, 1);

        run("hold5", 16'd12345, 8'd200, 5);

        bus.dividend = 16'd1700;
        bus.divisor  = 8'd100;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        reset_a = 1'b0;
        tick();
        chk("abort_e5", obs(), 32'd0);
        reset_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_after", obs(), 32'd0);
        end

        reset_a   = 1'b0;
        bus.start = 1'b1;
        tick();
        chk("rst_vs_start", obs(), 32'd0);
        bus.start = 1'b0;
        reset_a   = 1'b1;
        tick();
        tick();
        chk("rst_idle", obs(), 32'd0);
        run("post_rst", 16'd98, 8'd7, 1);

        for (int n = 0; n < 1000; n++) begin
            rd  = 16'($urandom);
            rv  = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                rv = 8'd0;
            else if (sel > 2 && rv != 8'd0)
                rd[15:8] = rd[15:8] % rv;
            run("rand", rd, rv, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/div16x8.md
DIV16X8 -- requirements
Module: div16x8

Interface
REQ-001 Parameters: none; operand widths are fixed at a 16-bit dividend and an 8-bit divisor.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_a  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 dividend  input  16  numerator, sampled only on a start edge.
REQ-005 divisor  input  8  denominator, sampled only on a start edge.
REQ-006 start  input  1  level; a high value sampled on any edge (re)launches a division.
REQ-007 quotient_out  output  8  registered quotient.
REQ-008 remainder_out  output  8  registered remainder.
REQ-009 done_flag  output  1  registered; high while the result outputs are valid.
REQ-010 div_zero_flag  output  1  registered; divisor was 0.
REQ-011 overflow_flag  output  1  registered; the quotient does not fit in 8 bits.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC, DONE.
REQ-013 start=1 on an edge, in any state, SHALL:
- capture dividend and divisor;
- clear quotient_out, remainder_out, done_flag, div_zero_flag and overflow_flag to 0;
- load the iteration counter with 0;
- enter CALC.
REQ-014 start SHALL take priority over every other transition, so an active division is aborted and restarted; while start stays high, all outputs stay 0.
REQ-015 CALC SHALL run a restoring shift-subtract division, one quotient bit per cycle, MSB first, for exactly 8 cycles, using a 9-bit trial subtraction.
REQ-016 Latency: with start sampled at edge E0 and no error, results and done_flag=1 SHALL be registered at edge E8; the state is then DONE.
REQ-017 Divide-by-zero (divisor=0) SHALL be detected at E1, with no iterations. Outputs: quotient_out=8'hFF, remainder_out=8'h00, div_zero_flag=1, overflow_flag=0, done_flag=1.
REQ-018 Overflow is defined as divisor!=0 and dividend[15:8] >= divisor. It SHALL be detected at E1. Outputs: quotient_out=8'hFF, remainder_out=8'h00, overflow_flag=1, div_zero_flag=0, done_flag=1.
REQ-019 Otherwise the results SHALL satisfy dividend = quotient_out*divisor + remainder_out, with remainder_out < divisor.
REQ-020 DONE SHALL hold all outputs stable until the next start or reset; with no start it SHALL remain in DONE. IDLE is only left on start.
REQ-021 quotient_out and remainder_out SHALL change only on a start edge, at the completion edge, or on reset. Intermediate partial values SHALL stay in internal registers.
REQ-022 Changes to dividend or divisor after the start edge SHALL have no effect on the active division.

Reset
REQ-023 reset_a=0 on an edge SHALL force IDLE and clear every output and internal register to 0.
REQ-024 Reset SHALL take priority over start and SHALL abort a division at any cycle; no stale done_flag may follow it.
REQ-025 The first edge with reset_a=1 and start=1 SHALL launch a division normally.

Structure
REQ-026 A shared package div_pkg SHALL hold:
- the state enum (IDLE, CALC, DONE);
- DVD_W=16, DVS_W=8, and the iteration count ITER=8;
- the error-result constants (8'hFF, 8'h00).
REQ-027 One combinational sub-module, div16x8_step, SHALL implement a single trial-subtract/shift step (9-bit partial remainder in, next partial remainder and quotient bit out), instantiated once.
REQ-028 The iteration counter SHALL be 4 bits wide; the CALC-to-DONE transition SHALL fire when the counter equals ITER-1.

Verification
REQ-029 Exact division: dividend=1700, divisor=100, one-cycle start -> at E8 quotient_out=17, remainder_out=0, done_flag=1, both error flags 0; values held until the next start.
REQ-030 Remainder and extreme value:
- 1705/100 -> quotient_out=17, remainder_out=5;
- 65024/255 -> quotient_out=254, remainder_out=254;
- 98/7 -> quotient_out=14, remainder_out=0.
REQ-031 Error cases:
- 1000/0 -> at E1 done_flag=1, div_zero_flag=1, quotient_out=8'hFF;
- 16'h1234/8'h12 -> at E1 overflow_flag=1, quotient_out=8'hFF.
REQ-032 Restart: start at E0 with 5358/57, then start at E4 with 7424/232 -> outputs 0 from E4, and at E12 quotient_out=32, remainder_out=0 (the first division is discarded).
REQ-033 Start held high for 5 cycles -> all outputs 0 throughout; the result is due 8 edges after the last high sample.
REQ-034 Reset: reset_a=0 at E5 of a division -> all outputs 0 at E5, state IDLE, and no done_flag afterwards; a random loop of 1000 operand pairs is checked against a reference model using REQ-019.
